// File: rtl/sort_4.sv
// Three-stage pipelined 4-input unsigned sorting network (ascending order).
// Every register advances only on enabled clock edges, so latency is counted in enabled edges.
module sort_4 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] small1,
    output logic [DATA_W-1:0] small2,
    output logic [DATA_W-1:0] large1,
    output logic [DATA_W-1:0] large2
);

    function automatic logic [DATA_W-1:0] umin(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
        return (x < y) ? x : y;
    endfunction

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
        return (x < y) ? y : x;
    endfunction

    logic [DATA_W-1:0] s1_a, s1_b, s1_c, s1_d;
    logic [DATA_W-1:0] s2_a, s2_b, s2_c, s2_d;

    // Stage 1: order each input pair.
    // NOTE: non-blocking assignments keep every stage sampling the previous stage's
    // pre-edge value; blocking here would collapse the pipeline into one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a <= '0;
            s1_b <= '0;
            s1_c <= '0;
            s1_d <= '0;
        end else if (en) begin
            s1_a <= umin(in1, in2);
            s1_b <= umax(in1, in2);
            s1_c <= umin(in3, in4);
            s1_d <= umax(in3, in4);
        end
    end

    // Stage 2: merge the pairs; global min and max are settled here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_a <= '0;
            s2_b <= '0;
            s2_c <= '0;
            s2_d <= '0;
        end else if (en) begin
            s2_a <= umin(s1_a, s1_c);
            s2_b <= umax(s1_a, s1_c);
            s2_c <= umin(s1_b, s1_d);
            s2_d <= umax(s1_b, s1_d);
        end
    end

    // Stage 3: order the two middle values into the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            small1 <= '0;
            small2 <= '0;
            large1 <= '0;
            large2 <= '0;
        end else if (en) begin
            small1 <= s2_a;
            small2 <= umin(s2_b, s2_c);
            large1 <= umax(s2_b, s2_c);
            large2 <= s2_d;
        end
    end

endmodule

// File: tb/tb_sort_4.sv
// Self-checking bench for sort_4: directed cases plus random traffic compared against
// a reference that sorts each accepted set and delays it by three enabled edges.
module tb_sort_4;

    localparam int DATA_W = 16;
    typedef logic [3:0][DATA_W-1:0] set_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] in1, in2, in3, in4;
    logic [DATA_W-1:0] small1, small2, large1, large2;

    int checks = 0;
    int errors = 0;

    set_t hist[$];

    sort_4 #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .small1(small1),
        .small2(small2),
        .large1(large1),
        .large2(large2)
    );

    always #5 clk = ~clk;

    function automatic set_t sort_set(input set_t v);
        set_t r = v;
        logic [DATA_W-1:0] t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j];
                    r[j] = r[j+1];
                    r[j+1] = t;
                end
        return r;
    endfunction

    function automatic set_t expected();
        set_t z = '0;
        return (hist.size() == 3) ? hist[0] : z;
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        set_t e = expected();
        check({tag, ".small1"}, small1, e[0]);
        check({tag, ".small2"}, small2, e[1]);
        check({tag, ".large1"}, large1, e[2]);
        check({tag, ".large2"}, large2, e[3]);
    endtask

    // Drive one cycle just after a falling edge, update the model at the rising edge,
    // and check the outputs at the next falling edge.
    task automatic step(input string tag, input logic en_v,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        set_t s;
        en  = en_v;
        in1 = a;
        in2 = b;
        in3 = c;
        in4 = d;
        @(posedge clk);
        if (!rst && en_v === 1'b1) begin
            s = {d, c, b, a};
            hist.push_back(sort_set(s));
            if (hist.size() > 3) void'(hist.pop_front());
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        hist.delete();
        check_outputs({tag, ".async"});
        @(negedge clk);
        check_outputs({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'bx;
        {in1, in2, in3, in4} = 'x;
        #1;
        check_outputs("reset");
        @(negedge clk);
        check_outputs("reset_cycle");
        rst = 1'b0;

        // Outputs remain zero until data has crossed three enabled edges.
        step("basic0", 1'b1, 16'd54, 16'd70, 16'd1, 16'd0);
        for (int i = 1; i < 6; i++) step("basic", 1'b1, 16'd54, 16'd70, 16'd1, 16'd0);
        for (int i = 0; i < 3; i++) step("basic_hold", 1'b0, 'x, 'x, 'x, 'x);

        // One enabled edge, a long stall with garbage inputs, then two more enabled edges.
        step("stall_in", 1'b1, 16'd9, 16'd3, 16'd7, 16'd5);
        for (int i = 0; i < 4; i++) step("stall", 1'b0, 16'hDEAD, 'x, 16'd0, 16'hFFFF);
        step("stall_e2", 1'b1, 16'd9, 16'd3, 16'd7, 16'd5);
        step("stall_e3", 1'b1, 16'd9, 16'd3, 16'd7, 16'd5);

        // Back-to-back sets with duplicates and unsigned extremes.
        step("dup", 1'b1, 16'd4, 16'd4, 16'd1, 16'd4);
        step("umax", 1'b1, 16'hFFFF, 16'd0, 16'hFFFF, 16'd1);
        step("sorted", 1'b1, 16'd1, 16'd2, 16'd3, 16'd4);
        step("reverse", 1'b1, 16'd4, 16'd3, 16'd2, 16'd1);
        for (int i = 0; i < 3; i++) step("drain", 1'b1, 16'd8, 16'd8, 16'd8, 16'd8);

        // Reset with sets in flight; only post-reset data may appear afterwards.
        step("pre_rst0", 1'b1, 16'd100, 16'd200, 16'd300, 16'd400);
        step("pre_rst1", 1'b1, 16'd11, 16'd22, 16'd33, 16'd44);
        async_reset("mid_reset");
        step("post_rst0", 1'b1, 16'd6, 16'd2, 16'd9, 16'd1);
        step("post_rst1", 1'b1, 16'd7, 16'd7, 16'd0, 16'd3);
        step("post_rst2", 1'b1, 16'd5, 16'd5, 16'd5, 16'd5);
        step("post_rst3", 1'b1, 16'd0, 16'd0, 16'd0, 16'd0);

        // Random traffic; narrow value ranges on some cycles force ties.
        for (int i = 0; i < 300; i++) begin
            logic [DATA_W-1:0] r[4];
            bit narrow = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++)
                r[k] = narrow ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
            step("random", ($urandom_range(0, 9) < 7), r[0], r[1], r[2], r[3]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
